// File: rtl/sdram_init_refresh_ctrl_if.sv
// Host/sequencer signal bundle for sdram_init_refresh_ctrl.
// The master side drives commands and acknowledges; the slave side is the controller.
interface sdram_init_refresh_ctrl_if #(
    parameter int ASIZE  = 23,
    parameter int DEBT_W = 3
);
    logic [2:0]        CMD;
    logic [ASIZE-1:0]  ADDR;
    logic              CM_ACK;
    logic              REF_ACK;
    logic              REINIT;
    logic              NOP;
    logic              READA;
    logic              WRITEA;
    logic [ASIZE-1:0]  SADDR;
    logic              CMD_ACK;
    logic              INIT_REQ;
    logic              PRECHARGE;
    logic              REFRESH;
    logic              LOAD_MODE;
    logic [ASIZE-1:0]  MODE_WORD;
    logic              INIT_DONE;
    logic              REF_REQ;
    logic              REF_URGENT;
    logic [DEBT_W-1:0] REF_DEBT;
    logic              REF_OVF;

    modport master (
        output CMD, ADDR, CM_ACK, REF_ACK, REINIT,
        input  NOP, READA, WRITEA, SADDR, CMD_ACK, INIT_REQ, PRECHARGE, REFRESH,
               LOAD_MODE, MODE_WORD, INIT_DONE, REF_REQ, REF_URGENT, REF_DEBT, REF_OVF
    );

    modport slave (
        input  CMD, ADDR, CM_ACK, REF_ACK, REINIT,
        output NOP, READA, WRITEA, SADDR, CMD_ACK, INIT_REQ, PRECHARGE, REFRESH,
               LOAD_MODE, MODE_WORD, INIT_DONE, REF_REQ, REF_URGENT, REF_DEBT, REF_OVF
    );
endinterface

// File: rtl/sdram_init_refresh_ctrl.sv
// SDRAM front-end: host command decode, power-up init sequencer and
// fixed-rate refresh scheduler with bounded postponed-refresh debt.
module sdram_init_refresh_ctrl #(
    parameter int ASIZE        = 23,
    parameter int CNT_W        = 16,
    parameter int INIT_PER     = 24000,
    parameter int INIT_GAP     = 20,
    parameter int INIT_REFS    = 8,
    parameter int REF_PER      = 1024,
    parameter int REF_DEBT_MAX = 4,
    parameter int SC_CL        = 3,
    parameter int SC_BL        = 1,
    parameter int SC_PM        = 1
) (
    input logic                    CLK,
    input logic                    RESET_N,
    sdram_init_refresh_ctrl_if.slave bus
);
    localparam int DEBT_W = $clog2(REF_DEBT_MAX + 1);
    localparam int RC_W   = (INIT_REFS > 1) ? $clog2(INIT_REFS) : 1;

    localparam logic [CNT_W-1:0]  INIT_PER_C = CNT_W'(INIT_PER);
    localparam logic [CNT_W-1:0]  GAP_C      = CNT_W'(INIT_GAP);
    localparam logic [CNT_W-1:0]  T_PRE      = CNT_W'(INIT_PER + INIT_GAP);
    localparam logic [CNT_W-1:0]  REF_LOAD   = CNT_W'(REF_PER - 1);
    localparam logic [RC_W-1:0]   REFS_LAST  = RC_W'(INIT_REFS - 1);
    localparam logic [DEBT_W-1:0] DEBT_MAX_C = DEBT_W'(REF_DEBT_MAX);

    localparam logic [2:0] BL_CODE = (SC_PM == 1) ? 3'b111 :
                                     (SC_BL == 8) ? 3'b011 :
                                     (SC_BL == 4) ? 3'b010 :
                                     (SC_BL == 2) ? 3'b001 : 3'b000;
    localparam logic [2:0] CL_CODE = (SC_CL == 2) ? 3'b010 : 3'b011;

    typedef enum logic [2:0] {S_WAIT, S_PRE, S_REF, S_LMR, S_DONE} state_t;

    state_t            state;
    logic [CNT_W-1:0]  ic;
    logic [CNT_W-1:0]  ic_next;
    logic [CNT_W-1:0]  tgt;
    logic [RC_W-1:0]   rc;
    logic [CNT_W-1:0]  timer;
    logic [DEBT_W-1:0] debt;
    logic              tick;

    assign ic_next = ic + CNT_W'(1);
    assign tick    = bus.INIT_DONE && (timer == '0);

    assign bus.MODE_WORD  = {{(ASIZE-7){1'b0}}, CL_CODE, 1'b0, BL_CODE};
    assign bus.REF_DEBT   = debt;
    assign bus.REF_REQ    = (debt != '0);
    assign bus.REF_URGENT = (debt == DEBT_MAX_C);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            bus.SADDR   <= '0;
            bus.NOP     <= 1'b0;
            bus.READA   <= 1'b0;
            bus.WRITEA  <= 1'b0;
            bus.CMD_ACK <= 1'b0;
        end else begin
            bus.SADDR   <= bus.ADDR;
            bus.NOP     <= (bus.CMD == 3'b000);
            bus.READA   <= (bus.CMD == 3'b001) && bus.INIT_DONE;
            bus.WRITEA  <= (bus.CMD == 3'b010) && bus.INIT_DONE;
            bus.CMD_ACK <= bus.CM_ACK && !bus.CMD_ACK;
        end
    end

    // tgt holds the ic value of the next init command, advanced by INIT_GAP
    // per command so no multiplier is needed.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state         <= S_WAIT;
            ic            <= '0;
            tgt           <= '0;
            rc            <= '0;
            bus.INIT_REQ  <= 1'b0;
            bus.PRECHARGE <= 1'b0;
            bus.REFRESH   <= 1'b0;
            bus.LOAD_MODE <= 1'b0;
            bus.INIT_DONE <= 1'b0;
        end else if (bus.REINIT) begin
            state         <= S_WAIT;
            ic            <= '0;
            tgt           <= '0;
            rc            <= '0;
            bus.INIT_REQ  <= 1'b0;
            bus.PRECHARGE <= 1'b0;
            bus.REFRESH   <= 1'b0;
            bus.LOAD_MODE <= 1'b0;
            bus.INIT_DONE <= 1'b0;
        end else begin
            bus.PRECHARGE <= 1'b0;
            bus.REFRESH   <= 1'b0;
            bus.LOAD_MODE <= 1'b0;
            bus.INIT_REQ  <= (state == S_WAIT) && (ic < INIT_PER_C);
            if (state != S_DONE) ic <= ic_next;
            case (state)
                S_WAIT: if (ic_next == INIT_PER_C) state <= S_PRE;
                S_PRE: begin
                    if (ic_next == T_PRE) begin
                        bus.PRECHARGE <= 1'b1;
                        tgt           <= T_PRE + GAP_C;
                        state         <= S_REF;
                    end
                end
                S_REF: begin
                    if (ic_next == tgt) begin
                        bus.REFRESH <= 1'b1;
                        tgt         <= tgt + GAP_C;
                        if (rc == REFS_LAST) state <= S_LMR;
                        else                 rc    <= rc + RC_W'(1);
                    end
                end
                S_LMR: begin
                    if (ic_next == tgt) begin
                        bus.LOAD_MODE <= 1'b1;
                        state         <= S_DONE;
                    end
                end
                S_DONE:  bus.INIT_DONE <= 1'b1;
                default: state <= S_WAIT;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            timer       <= '0;
            debt        <= '0;
            bus.REF_OVF <= 1'b0;
        end else if (bus.REINIT) begin
            timer <= '0;
            debt  <= '0;
        end else begin
            if (!bus.INIT_DONE) begin
                if (state == S_DONE) timer <= REF_LOAD;
            end else if (tick) begin
                timer <= REF_LOAD;
            end else begin
                timer <= timer - CNT_W'(1);
            end
            if (tick && !bus.REF_ACK) begin
                if (debt == DEBT_MAX_C) bus.REF_OVF <= 1'b1;
                else                    debt        <= debt + DEBT_W'(1);
            end else if (bus.REF_ACK && !tick && (debt != '0)) begin
                debt <= debt - DEBT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_sdram_init_refresh_ctrl.sv
// Bench for sdram_init_refresh_ctrl: directed plan points plus random traffic,
// checked against a cycle-count based reference model.
module tb_sdram_init_refresh_ctrl;
    localparam int ASIZE        = 23;
    localparam int INIT_PER     = 100;
    localparam int INIT_GAP     = 4;
    localparam int INIT_REFS    = 2;
    localparam int REF_PER      = 50;
    localparam int REF_DEBT_MAX = 2;
    localparam int DEBT_W       = $clog2(REF_DEBT_MAX + 1);
    localparam int T_LMR        = INIT_PER + INIT_GAP * (INIT_REFS + 2);

    logic CLK = 1'b0;
    logic RESET_N = 1'b0;
    always #5 CLK = ~CLK;

    logic [2:0]       cmd = '0;
    logic [ASIZE-1:0] addr = '0;
    logic             cm_ack = 1'b0;
    logic             ref_ack = 1'b0;
    logic             reinit = 1'b0;

    sdram_init_refresh_ctrl_if #(.ASIZE(ASIZE), .DEBT_W(DEBT_W)) bus ();

    assign bus.CMD     = cmd;
    assign bus.ADDR    = addr;
    assign bus.CM_ACK  = cm_ack;
    assign bus.REF_ACK = ref_ack;
    assign bus.REINIT  = reinit;

    sdram_init_refresh_ctrl #(
        .ASIZE(ASIZE), .CNT_W(16), .INIT_PER(INIT_PER), .INIT_GAP(INIT_GAP),
        .INIT_REFS(INIT_REFS), .REF_PER(REF_PER), .REF_DEBT_MAX(REF_DEBT_MAX),
        .SC_CL(3), .SC_BL(1), .SC_PM(1)
    ) dut (
        .CLK(CLK),
        .RESET_N(RESET_N),
        .bus(bus)
    );

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;

    // Reference model: r = edges since init start, debt as a plain integer.
    int               r = 0;
    int               m_debt = 0;
    bit               m_ovf = 0;
    bit               m_cack = 0;
    bit               m_done = 0;
    bit               e_nop = 0, e_reada = 0, e_writea = 0;
    logic [ASIZE-1:0] e_saddr = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
    endtask

    task automatic check_all();
        bit e_ref = 0;
        for (int i = 1; i <= INIT_REFS; i++)
            if (r == INIT_PER + INIT_GAP * (1 + i)) e_ref = 1;
        chk("NOP", 32'(bus.NOP), 32'(e_nop));
        chk("READA", 32'(bus.READA), 32'(e_reada));
        chk("WRITEA", 32'(bus.WRITEA), 32'(e_writea));
        chk("SADDR", 32'(bus.SADDR), 32'(e_saddr));
        chk("CMD_ACK", 32'(bus.CMD_ACK), 32'(m_cack));
        chk("INIT_REQ", 32'(bus.INIT_REQ), 32'(r >= 1 && r <= INIT_PER));
        chk("PRECHARGE", 32'(bus.PRECHARGE), 32'(r == INIT_PER + INIT_GAP));
        chk("REFRESH", 32'(bus.REFRESH), 32'(e_ref));
        chk("LOAD_MODE", 32'(bus.LOAD_MODE), 32'(r == T_LMR));
        chk("INIT_DONE", 32'(bus.INIT_DONE), 32'(m_done));
        chk("REF_DEBT", 32'(bus.REF_DEBT), 32'(m_debt));
        chk("REF_REQ", 32'(bus.REF_REQ), 32'(m_debt != 0));
        chk("REF_URGENT", 32'(bus.REF_URGENT), 32'(m_debt == REF_DEBT_MAX));
        chk("REF_OVF", 32'(bus.REF_OVF), 32'(m_ovf));
        chk("MODE_WORD", 32'(bus.MODE_WORD), 32'h37);
    endtask

    task automatic step();
        bit tick;
        bit prev_done;
        @(posedge CLK);
        cyc++;
        prev_done = m_done;
        e_nop     = (cmd == 3'd0);
        e_reada   = (cmd == 3'd1) && prev_done;
        e_writea  = (cmd == 3'd2) && prev_done;
        e_saddr   = addr;
        m_cack    = cm_ack && !m_cack;
        if (reinit) r = 0;
        else        r++;
        m_done = (r >= T_LMR + 1);
        tick = !reinit && (r >= T_LMR + 1 + REF_PER) && ((r - T_LMR - 1) % REF_PER == 0);
        if (reinit) m_debt = 0;
        else if (tick && !ref_ack) begin
            if (m_debt == REF_DEBT_MAX) m_ovf = 1;
            else m_debt++;
        end else if (ref_ack && !tick && m_debt > 0) m_debt--;
        #1;
        check_all();
    endtask

    task automatic quiet();
        cmd = 3'd0; cm_ack = 1'b0; ref_ack = 1'b0; reinit = 1'b0;
    endtask

    task automatic model_reset();
        r = 0; m_debt = 0; m_ovf = 0; m_cack = 0; m_done = 0;
        e_nop = 0; e_reada = 0; e_writea = 0; e_saddr = '0;
        cyc = 0;
    endtask

    initial begin
        repeat (3) @(posedge CLK);
        #1;
        model_reset();
        check_all();
        RESET_N = 1'b1;

        // Directed run following the plan's cycle numbers.
        for (int c = 0; c < 600; c++) begin
            quiet();
            addr = ASIZE'($urandom);
            if (c == 50) cmd = 3'd1;
            if (c == 200) begin cmd = 3'd2; addr = 23'h12345; end
            cm_ack  = (c >= 130 && c <= 133);
            ref_ack = (c == 140 || c == 270 || c == 517);
            reinit  = (c == 300);
            step();
            case (cyc)
                1, 100: chk("ireq_on", 32'(bus.INIT_REQ), 32'd1);
                101: chk("ireq_off", 32'(bus.INIT_REQ), 32'd0);
                51: begin
                    chk("reada_gated", 32'(bus.READA), 32'd0);
                    chk("nop_on_reada", 32'(bus.NOP), 32'd0);
                end
                104, 405: chk("pre_pulse", 32'(bus.PRECHARGE), 32'd1);
                108, 112: chk("ref_pulse", 32'(bus.REFRESH), 32'd1);
                116: begin
                    chk("lmr_pulse", 32'(bus.LOAD_MODE), 32'd1);
                    chk("done_not_yet", 32'(bus.INIT_DONE), 32'd0);
                end
                117: chk("done_set", 32'(bus.INIT_DONE), 32'd1);
                131, 132, 133, 134: chk("cmd_ack_train", 32'(bus.CMD_ACK), 32'(cyc == 131 || cyc == 133));
                141, 166: chk("debt_zero", 32'(bus.REF_DEBT), 32'd0);
                167: chk("debt_one", 32'(bus.REF_DEBT), 32'd1);
                201: begin
                    chk("writea", 32'(bus.WRITEA), 32'd1);
                    chk("saddr", 32'(bus.SADDR), 32'h12345);
                end
                217: begin
                    chk("debt_two", 32'(bus.REF_DEBT), 32'd2);
                    chk("urgent", 32'(bus.REF_URGENT), 32'd1);
                end
                266: chk("ovf_clear", 32'(bus.REF_OVF), 32'd0);
                267: begin
                    chk("ovf_set", 32'(bus.REF_OVF), 32'd1);
                    chk("debt_sat", 32'(bus.REF_DEBT), 32'd2);
                end
                301: begin
                    chk("reinit_done", 32'(bus.INIT_DONE), 32'd0);
                    chk("reinit_debt", 32'(bus.REF_DEBT), 32'd0);
                    chk("reinit_ovf", 32'(bus.REF_OVF), 32'd1);
                end
                518: chk("tick_ack", 32'(bus.REF_DEBT), 32'd1);
                default: ;
            endcase
        end

        // Random traffic.
        for (int c = 0; c < 2500; c++) begin
            cmd     = 3'($urandom_range(0, 7));
            addr    = ASIZE'($urandom);
            cm_ack  = 1'($urandom_range(0, 1));
            ref_ack = ($urandom_range(0, 29) == 0);
            reinit  = ($urandom_range(0, 699) == 0);
            step();
        end

        // Restart init, then pull reset asynchronously between the refreshes.
        quiet();
        reinit = 1'b1;
        step();
        reinit = 1'b0;
        for (int c = 0; c < 110; c++) step();
        chk("in_ref_state", 32'(r), 32'd110);
        #2;
        RESET_N = 1'b0;
        #1;
        chk("arst_ireq", 32'(bus.INIT_REQ), 32'd0);
        chk("arst_ovf", 32'(bus.REF_OVF), 32'd0);
        chk("arst_debt", 32'(bus.REF_DEBT), 32'd0);
        chk("arst_req", 32'(bus.REF_REQ), 32'd0);
        chk("arst_nop", 32'(bus.NOP), 32'd0);
        chk("arst_saddr", 32'(bus.SADDR), 32'd0);
        chk("arst_cmdack", 32'(bus.CMD_ACK), 32'd0);
        chk("arst_refresh", 32'(bus.REFRESH), 32'd0);
        chk("arst_done", 32'(bus.INIT_DONE), 32'd0);
        chk("arst_mode", 32'(bus.MODE_WORD), 32'h37);
        repeat (2) @(posedge CLK);
        #1;
        model_reset();
        RESET_N = 1'b1;
        for (int c = 0; c < 130; c++) begin
            addr = ASIZE'($urandom);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/sdram_init_refresh_ctrl.md
# sdram_init_refresh_ctrl

Parametrised SDRAM controller front-end sitting between the host command port and the SDRAM command sequencer. It registers and decodes host commands. It generates a configurable power-up sequence: wait, precharge-all, N auto-refreshes, then load-mode. It runs a fixed-rate refresh scheduler with a bounded postponed-refresh debt counter and overflow flag. It also supports a software-triggered re-initialisation without a hard reset.

## Interface

Parameters:
- ASIZE, 23, host/SDRAM address width (must be ≥ 10).
- CNT_W, 16, width of the init and refresh counters.
- INIT_PER, 24000, power-up wait in cycles (INIT_REQ high).
- INIT_GAP, 20, cycles between successive init commands.
- INIT_REFS, 8, auto-refreshes issued during init (≥ 1).
- REF_PER, 1024, cycles between refresh ticks.
- REF_DEBT_MAX, 4, maximum outstanding refreshes (≥ 1).
- SC_CL, 3, CAS latency (2 or 3).
- SC_BL, 1, burst length (1/2/4/8).
- SC_PM, 1, page mode; 1 selects full-page burst.

Ports:
- CLK, in, 1, system clock.
- RESET_N, in, 1, asynchronous active-low reset.
- CMD, in, 3, host command: 000 NOP, 001 READA, 010 WRITEA, others ignored.
- ADDR, in, ASIZE, host address.
- CM_ACK, in, 1, sequencer command acknowledge.
- REF_ACK, in, 1, one-cycle pulse when the sequencer completes a refresh.
- REINIT, in, 1, one-cycle pulse that restarts the init sequence.
- NOP / READA / WRITEA, out, 1 each, registered command decode.
- SADDR, out, ASIZE, registered ADDR.
- CMD_ACK, out, 1, host acknowledge pulse.
- INIT_REQ, out, 1, high during the power-up wait.
- PRECHARGE / REFRESH / LOAD_MODE, out, 1 each, one-cycle init command pulses.
- MODE_WORD, out, ASIZE, mode register value (constant).
- INIT_DONE, out, 1, init complete (sticky).
- REF_REQ, out, 1, refresh debt ≠ 0.
- REF_URGENT, out, 1, refresh debt = REF_DEBT_MAX.
- REF_DEBT, out, $clog2(REF_DEBT_MAX+1), outstanding refresh count.
- REF_OVF, out, 1, sticky refresh-overflow error.

## Operation

- **Reset.** All registered outputs are 0, init state is WAIT, counters are 0, debt is 0. MODE_WORD is combinational and constant.
- **Decode.** Every cycle: SADDR<=ADDR; NOP<=(CMD==000); READA<=(CMD==001)&INIT_DONE; WRITEA<=(CMD==010)&INIT_DONE. Read and write commands are suppressed until init completes.
- **CMD_ACK.** CMD_ACK<=CM_ACK&~CMD_ACK. A held CM_ACK therefore produces an alternating pulse train.
- **MODE_WORD.**
  - Bits [2:0] are the burst-length code: 111 if SC_PM=1; otherwise BL 1/2/4/8 → 000/001/010/011.
  - Bit 3 = 0 (sequential burst).
  - Bits [6:4] = 010 for CL2, 011 for CL3.
  - All upper bits are 0.
- **Init FSM states:** WAIT → PRE → REF → LMR → DONE. A single counter ic counts edges since entry to WAIT.
  - WAIT: INIT_REQ=1 while ic<INIT_PER.
  - PRE: PRECHARGE pulses when ic = INIT_PER+INIT_GAP.
  - REF: REFRESH pulses when ic = INIT_PER+INIT_GAP·(1+i), for i = 1..INIT_REFS.
  - LMR: LOAD_MODE pulses when ic = INIT_PER+INIT_GAP·(INIT_REFS+2) = T_LMR.
  - DONE: INIT_DONE=1 from T_LMR+1. The counter stops.
- **REINIT.** When REINIT=1 (any state), on the next edge:
  - the FSM enters WAIT and ic restarts;
  - INIT_DONE, REF_DEBT and the refresh timer clear;
  - REF_OVF is kept.
- **Refresh scheduler.**
  - The timer is held while INIT_DONE=0.
  - It loads REF_PER−1 on the edge where INIT_DONE rises, then decrements.
  - At 0 it reloads REF_PER−1 and produces a tick.
  - REF_ACK does not touch the timer (fixed rate).
- **Debt update:**
  - tick & ~ack: debt+1; if already at REF_DEBT_MAX, debt stays and REF_OVF<=1 (sticky until reset).
  - ack & ~tick: debt−1; ignored if debt is 0.
  - tick & ack: debt unchanged.
- **Flags.** REF_REQ = (debt≠0); REF_URGENT = (debt==REF_DEBT_MAX). Both are decoded from the debt register.

## Timing

- "Cycle k" means the registered value after the k-th rising edge following RESET_N deassertion (or following the REINIT edge).
- Decode latency is 1 cycle. CMD_ACK latency is 1 cycle.
- INIT_REQ is high for cycles 1..INIT_PER.
- PRECHARGE, REFRESH and LOAD_MODE are exactly one cycle wide and mutually exclusive.
- The first tick raises REF_REQ at cycle T_LMR+1+REF_PER. Each further tick follows REF_PER cycles later.
- REF_ACK takes effect on REF_DEBT one cycle after it is sampled.
- Asynchronous reset mid-sequence returns all outputs to 0 immediately, without waiting for a clock edge.

## Test plan

Bench parameters: INIT_PER=100, INIT_GAP=4, INIT_REFS=2, REF_PER=50, REF_DEBT_MAX=2, ASIZE=23.

- **Init sequence.** Release reset with no activity → INIT_REQ high for cycles 1..100; PRECHARGE at 104; REFRESH at 108 and 112; LOAD_MODE at 116; INIT_DONE from 117. MODE_WORD=0x37.
- **Decode gating.**
  - CMD=001 at cycle 50 → READA stays 0, NOP=0.
  - CMD=010, ADDR=0x12345 at cycle 200 → WRITEA=1 and SADDR=0x12345 at cycle 201.
- **Debt and overflow.** No REF_ACK → REF_DEBT=1 at 167, 2 at 217 with REF_URGENT=1, REF_OVF=1 at 267 with debt still 2.
- **Acknowledge handling.**
  - REF_ACK at a tick edge with debt 1 → debt stays 1.
  - REF_ACK with debt 0 → debt stays 0.
  - CM_ACK held for 4 cycles → CMD_ACK pattern 1,0,1,0.
- **Re-initialisation.**
  - REINIT at cycle 300 → INIT_DONE=0 and REF_DEBT=0 at 301; PRECHARGE 104 cycles later; REF_OVF retained.
  - Assert RESET_N low mid-REF state → all outputs 0 asynchronously.
